// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU, FPU and load results onto two registered register-file write ports.
// Latency: ALU 1 edge to port flops; FPU/load 2 edges (enqueue, then issue from queue).
// Backpressure: ALU never stalls; fpu_ready/mem_ready drop when fewer than two queue slots are free.
//
// Ports: clk/rstn (async active-low reset); alu_valid/alu_rd/alu_data (no ready);
// fpu_valid/fpu_ready/fpu_rd/fpu_data and mem_valid/mem_ready/mem_rd/mem_data (valid-ready);
// we1/aw1/wd1 and we2/aw2/wd2 registered write ports; empty = queue empty and no write pending.
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        alu_valid,
    input  logic [5:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        fpu_valid,
    output logic        fpu_ready,
    input  logic [5:0]  fpu_rd,
    input  logic [31:0] fpu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [5:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        we1,
    output logic [5:0]  aw1,
    output logic [31:0] wd1,
    output logic        we2,
    output logic [5:0]  aw2,
    output logic [31:0] wd2,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic [5:0]    q_rd   [DEPTH];
    logic [31:0]   q_data [DEPTH];

    logic          mem_enq, fpu_enq, alu_use;
    logic [1:0]    enq_n, deq_n;
    logic [AW-1:0] sec_idx;
    logic          n_we1, n_we2;
    logic [5:0]    n_aw1, n_aw2;
    logic [31:0]   n_wd1, n_wd2;

    // Two free slots required so a simultaneous FPU+load transfer always fits.
    // Driven from the registered count only, so there is no valid->ready path.
    assign fpu_ready = (count <= CW'(DEPTH - 2));
    assign mem_ready = fpu_ready;

    // rd==0 transfers complete the handshake but are dropped.
    assign mem_enq = mem_valid & mem_ready & (mem_rd != 6'd0);
    assign fpu_enq = fpu_valid & fpu_ready & (fpu_rd != 6'd0);
    assign enq_n   = {1'b0, mem_enq} + {1'b0, fpu_enq};
    assign alu_use = alu_valid & (alu_rd != 6'd0);
    assign sec_idx = rd_ptr + AW'(1);

    assign empty = (count == '0) & ~we1 & ~we2;

    // Issue selection looks only at entries present before this edge, so a
    // freshly enqueued result waits one cycle before it can issue.
    always_comb begin
        n_we1 = 1'b0;
        n_aw1 = 6'd0;
        n_wd1 = 32'd0;
        n_we2 = 1'b0;
        n_aw2 = 6'd0;
        n_wd2 = 32'd0;
        deq_n = 2'd0;
        if (alu_use) begin
            n_we1 = 1'b1;
            n_aw1 = alu_rd;
            n_wd1 = alu_data;
            if (count != '0) begin
                n_we2 = 1'b1;
                n_aw2 = q_rd[rd_ptr];
                n_wd2 = q_data[rd_ptr];
                deq_n = 2'd1;
            end
        end else begin
            if (count != '0) begin
                n_we1 = 1'b1;
                n_aw1 = q_rd[rd_ptr];
                n_wd1 = q_data[rd_ptr];
                deq_n = 2'd1;
            end
            if (count >= CW'(2)) begin
                n_we2 = 1'b1;
                n_aw2 = q_rd[sec_idx];
                n_wd2 = q_data[sec_idx];
                deq_n = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            we1    <= 1'b0;
            aw1    <= 6'd0;
            wd1    <= 32'd0;
            we2    <= 1'b0;
            aw2    <= 6'd0;
            wd2    <= 32'd0;
        end else begin
            rd_ptr <= rd_ptr + AW'(deq_n);
            wr_ptr <= wr_ptr + AW'(enq_n);
            count  <= count + CW'(enq_n) - CW'(deq_n);
            we1    <= n_we1;
            aw1    <= n_aw1;
            wd1    <= n_wd1;
            we2    <= n_we2;
            aw2    <= n_aw2;
            wd2    <= n_wd2;
        end
    end

    // Storage is not reset; stray writes while in reset are harmless since count stays 0.
    // Load entry takes the first free slot, FPU entry the next.
    always_ff @(posedge clk) begin
        if (mem_enq) begin
            q_rd[wr_ptr]   <= mem_rd;
            q_data[wr_ptr] <= mem_data;
        end
        if (fpu_enq) begin
            q_rd[mem_enq ? wr_ptr + AW'(1) : wr_ptr]   <= fpu_rd;
            q_data[mem_enq ? wr_ptr + AW'(1) : wr_ptr] <= fpu_data;
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter: randomized and directed stimulus against a queue-based reference model.
// Latency: outputs compared #1 after each rising edge against the model's expected port values.
// Backpressure: model ready follows the two-free-slot rule; stalls are exercised and observed.
module tb_wb_arbiter;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        alu_valid, fpu_valid, mem_valid;
    logic [5:0]  alu_rd, fpu_rd, mem_rd;
    logic [31:0] alu_data, fpu_data, mem_data;
    logic        fpu_ready, mem_ready;
    logic        we1, we2, empty;
    logic [5:0]  aw1, aw2;
    logic [31:0] wd1, wd2;

    typedef struct packed {
        logic [5:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    int   errors = 0;
    int   checks = 0;
    bit   saw_stall = 0;
    int   wrap_rd[$];

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_rd(fpu_rd), .fpu_data(fpu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .we1(we1), .aw1(aw1), .wd1(wd1),
        .we2(we2), .aw2(aw2), .wd2(wd2),
        .empty(empty)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        fpu_valid = 0; fpu_rd = 0; fpu_data = 0;
        mem_valid = 0; mem_rd = 0; mem_data = 0;
    endtask

    // One clock cycle: inputs are already driven; predict from the model, advance, compare.
    task automatic step();
        ent_t        e;
        bit          rdy;
        logic        ew1, ew2;
        logic [5:0]  ea1, ea2;
        logic [31:0] ed1, ed2;
        rdy = (mq.size() <= DEPTH - 2);
        if (!rdy) saw_stall = 1;
        check("fpu_ready", fpu_ready, rdy);
        check("mem_ready", mem_ready, rdy);
        ew1 = 0; ea1 = 0; ed1 = 0;
        ew2 = 0; ea2 = 0; ed2 = 0;
        if (alu_valid && alu_rd != 0) begin
            ew1 = 1; ea1 = alu_rd; ed1 = alu_data;
            if (mq.size() > 0) begin
                e = mq.pop_front();
                ew2 = 1; ea2 = e.rd; ed2 = e.data;
            end
        end else begin
            if (mq.size() > 0) begin
                e = mq.pop_front();
                ew1 = 1; ea1 = e.rd; ed1 = e.data;
            end
            if (mq.size() > 0) begin
                e = mq.pop_front();
                ew2 = 1; ea2 = e.rd; ed2 = e.data;
            end
        end
        if (rdy && mem_valid && mem_rd != 0) mq.push_back({mem_rd, mem_data});
        if (rdy && fpu_valid && fpu_rd != 0) mq.push_back({fpu_rd, fpu_data});
        @(posedge clk);
        #1;
        check("we1", we1, ew1);
        check("aw1", aw1, ea1);
        check("wd1", wd1, ed1);
        check("we2", we2, ew2);
        check("aw2", aw2, ea2);
        check("wd2", wd2, ed2);
        check("empty", empty, (mq.size() == 0) && !ew1 && !ew2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we1"}, we1, 0);
        check({tag, "_we2"}, we2, 0);
        check({tag, "_aw1"}, aw1, 0);
        check({tag, "_aw2"}, aw2, 0);
        check({tag, "_wd1"}, wd1, 0);
        check({tag, "_wd2"}, wd2, 0);
        check({tag, "_frdy"}, fpu_ready, 1);
        check({tag, "_mrdy"}, mem_ready, 1);
        check({tag, "_empty"}, empty, 1);
    endtask

    initial begin
        rstn = 0;
        idle_inputs();
        #2;
        check_reset_outputs("rst");
        @(posedge clk); #1;
        rstn = 1;

        // ALU only
        alu_valid = 1; alu_rd = 6'd5; alu_data = 32'h1234_5678;
        step();
        check("alu_only_we1", we1, 1);
        check("alu_only_aw1", aw1, 5);
        check("alu_only_wd1", wd1, 32'h1234_5678);
        check("alu_only_we2", we2, 0);
        idle_inputs();
        step();

        // Simultaneous ALU r3, FPU r7, load r9
        alu_valid = 1; alu_rd = 3; alu_data = 32'hA3;
        fpu_valid = 1; fpu_rd = 7; fpu_data = 32'hF7;
        mem_valid = 1; mem_rd = 9; mem_data = 32'hB9;
        step();
        check("sim_c1_aw1", aw1, 3);
        check("sim_c1_we2", we2, 0);
        idle_inputs();
        step();
        check("sim_c2_aw1", aw1, 9);
        check("sim_c2_aw2", aw2, 7);
        step();

        // rd=0 discard
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1;
        fpu_valid = 1; fpu_rd = 0; fpu_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        step();
        check("rd0_we1", we1, 0);
        check("rd0_we2", we2, 0);
        check("rd0_empty", empty, 1);

        // Backpressure: everything valid every cycle
        for (int i = 0; i < 24; i++) begin
            alu_valid = 1; alu_rd = 6'(1 + (i % 60)); alu_data = 32'h1000 + i;
            fpu_valid = 1; fpu_rd = 6'(2 + (i % 60)); fpu_data = 32'h2000 + i;
            mem_valid = 1; mem_rd = 6'(3 + (i % 60)); mem_data = 32'h3000 + i;
            step();
        end
        check("bp_stall_seen", saw_stall, 1);
        idle_inputs();
        for (int i = 0; i < DEPTH + 2; i++) step();
        check("bp_drained_empty", empty, 1);

        // Wrap-around: 10 loads, no ALU
        for (int n = 1; n <= 10; n++) begin
            mem_valid = 1; mem_rd = 6'(n); mem_data = 32'(n * 16);
            step();
            if (we1) wrap_rd.push_back(int'(aw1));
            if (we2) wrap_rd.push_back(int'(aw2));
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            if (we1) wrap_rd.push_back(int'(aw1));
            if (we2) wrap_rd.push_back(int'(aw2));
        end
        check("wrap_count", wrap_rd.size(), 10);
        for (int i = 0; i < 10 && i < wrap_rd.size(); i++) check("wrap_order", wrap_rd[i], i + 1);
        check("wrap_empty", empty, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            alu_valid = ($urandom_range(0, 2) == 0);
            alu_rd    = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
            alu_data  = $urandom;
            fpu_valid = $urandom_range(0, 1);
            fpu_rd    = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
            fpu_data  = $urandom;
            mem_valid = $urandom_range(0, 1);
            mem_rd    = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
            mem_data  = $urandom;
            step();
        end
        idle_inputs();
        for (int i = 0; i < DEPTH + 2; i++) step();

        // Reset mid-traffic with three entries queued
        alu_valid = 1; alu_rd = 20; alu_data = 32'h20;
        fpu_valid = 1; fpu_rd = 21; fpu_data = 32'h21;
        mem_valid = 1; mem_rd = 22; mem_data = 32'h22;
        step();
        alu_rd = 23; fpu_rd = 24; mem_rd = 25;
        step();
        check("pre_rst_ready", fpu_ready, 0);
        rstn = 0;
        #1;
        check_reset_outputs("midrst");
        mq.delete();
        @(posedge clk); #1;
        check_reset_outputs("inrst");
        rstn = 1;
        idle_inputs();
        fpu_valid = 1; fpu_rd = 12; fpu_data = 32'hC0FFEE;
        step();
        check("post_rst_e0_we1", we1, 0);
        idle_inputs();
        step();
        check("post_rst_e1_we1", we1, 1);
        check("post_rst_e1_aw1", aw1, 12);
        check("post_rst_e1_wd1", wd1, 32'hC0FFEE);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
